alsu_driver: RTL and testbench
==============================

# alsu_driver

Command-side front end for the ALSU. It accepts packed 16-bit ALSU commands over a valid/ready interface, buffers them in a small FIFO, and rejects illegal combinations itself so they never reach the ALSU. Legal commands are driven onto the ALSU input pins, the registered ALSU result is sampled after a fixed latency, and the result is returned over a second valid/ready interface. The block sits between the test/host logic and the ALSU instance.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of 2, 2..16.
- ALSU_LATENCY, 2, clock edges from a drive-pin change until `alsu_out` reflects it.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_data  in  16  fields: [15:13] A, [12:10] B, [9:7] opcode, [6] cin, [5] serial_in, [4] direction, [3] red_op_A, [2] red_op_B, [1] bypass_A, [0] bypass_B.
- A, B, opcode  out  3 each  ALSU drive pins.
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  out  1 each  ALSU drive pins.
- alsu_out  in  6  ALSU result.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response accepted.
- rsp_data  out  6  sampled result; 0 on error.
- rsp_err  out  1  command was rejected.
- busy  out  1  FSM not in IDLE or FIFO not empty.
- err_count  out  8  rejected commands, saturates at 255.

## Operation
- Push: `cmd_valid && cmd_ready` writes `cmd_data` at the tail. A push while full is impossible because `cmd_ready` is 0.
- Illegal command: `opcode` is 6 or 7; or `red_op_A` or `red_op_B` is set while `opcode` is not 0 or 1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE, FIFO not empty: pop the head into the command register.
    - If the command is illegal: set `rsp_data` = 0, `rsp_err` = 1, increment `err_count` (saturating), go to RESP. The drive pins are not updated.
    - Otherwise go to ISSUE.
  - ISSUE: load all drive pins from the command register. Load the wait counter with ALSU_LATENCY-1. Go to WAIT.
  - WAIT: decrement the counter. When it reaches 0, sample `alsu_out` into `rsp_data`, set `rsp_err` = 0, go to RESP.
  - RESP: hold `rsp_valid` = 1 with `rsp_data` and `rsp_err` stable until `rsp_ready` = 1. On that handshake, go to IDLE.
- Drive pins hold their last legal value in every state. The ALSU keeps evaluating every cycle, so shift/rotate opcodes (4, 5) continue to act while the pins are held; responses reflect only the sampled cycle.
- One command is in flight at a time. No pop happens outside IDLE.
- Simultaneous push and pop in the same cycle are both performed; the count is unchanged.

## Timing
- Reset values:
  - FIFO empty, `cmd_ready` = 1.
  - All drive pins = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0.
  - `busy` = 0, `err_count` = 0.
  - FSM = IDLE.
- Legal command, pushed at edge T into an empty FIFO with the FSM in IDLE:
  - Popped at T+1.
  - Pins driven at T+2.
  - `rsp_data` sampled at edge T+2+ALSU_LATENCY.
  - `rsp_valid` asserted from that edge on.
- Illegal command: `rsp_valid` asserts at the edge after the pop, i.e. T+2 for the case above.
- `rsp_valid` falls on the edge where `rsp_ready` is sampled high. The next pop occurs no earlier than the following edge.
- Reset asserted mid-operation:
  - All state clears immediately.
  - Any in-flight command and all FIFO contents are discarded.
  - No response is produced for them.
- `busy` is combinational from the FSM state and the FIFO count.

## Test plan
- Reset then idle: `cmd_ready` = 1, `rsp_valid` = 0, `busy` = 0, all pins 0, `err_count` = 0.
- Push A=3, B=5, opcode=2, cin=1 (ALSU with FULL_ADDER on), `rsp_ready` held 1:
  - Pins are driven 2 edges after the push.
  - `rsp_valid` rises 4 edges after the push.
  - `rsp_data` = 9, `rsp_err` = 0.
- Illegal commands:
  - Push opcode=7: response `rsp_err` = 1, `rsp_data` = 0, pins unchanged, `err_count` = 1.
  - Push opcode=3 with red_op_A=1: `err_count` = 2.
- Backpressure:
  - Hold `rsp_ready` = 0 and push 1+FIFO_DEPTH commands. `cmd_ready` drops after FIFO_DEPTH+1 pushes (one popped, FIFO full).
  - Release `rsp_ready`. All responses return in order with the expected values: opcode 3 with A=2, B=3 returns 6.
- Reset mid-operation: assert `rst` during WAIT with 3 commands queued. Outputs clear asynchronously, and no stale response appears after release.
- Saturation: push 260 illegal commands; `err_count` stops at 255.

Source files
------------

// File: rtl/alsu_driver.sv
// alsu_driver
//   Command-side front end for the ALSU. Packed 16-bit commands arrive over a
//   valid/ready interface and are buffered in a small FIFO. Illegal commands
//   are answered locally with an error response and never reach the ALSU.
//   Legal commands are driven onto the ALSU pins, the ALSU result is sampled
//   after ALSU_LATENCY edges, and the result is returned over a second
//   valid/ready interface. Only one command is in flight at a time.
//
// Parameters
//   FIFO_DEPTH    command FIFO entries (power of 2, 2..16)
//   ALSU_LATENCY  edges from a drive-pin change until alsu_out reflects it
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cmd_valid/ready/data     command input; data = {A,B,opcode,cin,serial_in,
//                            direction,red_op_A,red_op_B,bypass_A,bypass_B}
//   A, B, opcode, cin, serial_in, direction, red_op_A, red_op_B,
//   bypass_A, bypass_B       registered ALSU drive pins
//   alsu_out                 ALSU result
//   rsp_valid/ready/data/err response output; data is 0 on error
//   busy                     FSM not idle or FIFO not empty
//   err_count                saturating count of rejected commands
module alsu_driver #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ALSU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  output logic [2:0]  A,
  output logic [2:0]  B,
  output logic [2:0]  opcode,
  output logic        cin,
  output logic        serial_in,
  output logic        direction,
  output logic        red_op_A,
  output logic        red_op_B,
  output logic        bypass_A,
  output logic        bypass_B,
  input  logic [5:0]  alsu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LW = (ALSU_LATENCY > 1) ? $clog2(ALSU_LATENCY) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [LW-1:0] WAIT_LOAD  = LW'(ALSU_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_a;
    logic       red_b;
    logic       byp_a;
    logic       byp_b;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  state_t        state;
  cmd_t          cmd_reg;
  logic [LW-1:0] wait_cnt;
  logic          cmd_illegal;

  assign cmd_ready = (count != FULL_COUNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign busy      = (state != IDLE) || (count != '0);

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= cmd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Legality: opcodes 6/7 are invalid, reductions only apply to opcodes 0/1.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_illegal = 1'b0;
    if ((cmd_reg.op == 3'd6) || (cmd_reg.op == 3'd7)) begin
      cmd_illegal = 1'b1;
    end
    if ((cmd_reg.red_a || cmd_reg.red_b) && (cmd_reg.op > 3'd1)) begin
      cmd_illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // The legality check is evaluated on the command register in ISSUE, the
  // cycle after the pop, so an error response appears one edge after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_reg   <= '0;
      wait_cnt  <= '0;
      A         <= '0;
      B         <= '0;
      opcode    <= '0;
      cin       <= 1'b0;
      serial_in <= 1'b0;
      direction <= 1'b0;
      red_op_A  <= 1'b0;
      red_op_B  <= 1'b0;
      bypass_A  <= 1'b0;
      bypass_B  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cmd_reg <= cmd_t'(mem[head]);
            state   <= ISSUE;
          end
        end

        ISSUE: begin
          if (cmd_illegal) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            if (err_count != 8'hFF) begin
              err_count <= err_count + 1'b1;
            end
            state <= RESP;
          end else begin
            A         <= cmd_reg.a;
            B         <= cmd_reg.b;
            opcode    <= cmd_reg.op;
            cin       <= cmd_reg.cin;
            serial_in <= cmd_reg.serial_in;
            direction <= cmd_reg.direction;
            red_op_A  <= cmd_reg.red_a;
            red_op_B  <= cmd_reg.red_b;
            bypass_A  <= cmd_reg.byp_a;
            bypass_B  <= cmd_reg.byp_b;
            wait_cnt  <= WAIT_LOAD;
            state     <= WAIT;
          end
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_data  <= alsu_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_driver.sv
// Testbench for alsu_driver. A behavioural ALSU stand-in registers its result
// once from the (already registered) drive pins, giving two edges from the
// driver's pin update to a visible alsu_out. Expected responses are queued when
// commands are pushed and checked when the driver presents a response.
module tb_alsu_driver;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_data = '0;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B;
  logic [5:0]  alsu_out = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  err_count;

  logic [15:0] pins;
  assign pins = {A, B, opcode, cin, serial_in, direction,
                 red_op_A, red_op_B, bypass_A, bypass_B};

  typedef struct {
    logic [5:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alsu_driver #(
    .FIFO_DEPTH  (DEPTH),
    .ALSU_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .cin      (cin),
    .serial_in(serial_in),
    .direction(direction),
    .red_op_A (red_op_A),
    .red_op_B (red_op_B),
    .bypass_A (bypass_A),
    .bypass_B (bypass_B),
    .alsu_out (alsu_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .err_count(err_count)
  );

  // ALSU stand-in
  always @(posedge clk) begin
    if (bypass_A)      alsu_out <= {3'b000, A};
    else if (bypass_B) alsu_out <= {3'b000, B};
    else begin
      case (opcode)
        3'd0: alsu_out <= red_op_A ? {5'b0, &A} : red_op_B ? {5'b0, &B} : {3'b000, A & B};
        3'd1: alsu_out <= red_op_A ? {5'b0, ^A} : red_op_B ? {5'b0, ^B} : {3'b000, A ^ B};
        3'd2: alsu_out <= {3'b000, A} + {3'b000, B} + {5'b0, cin};
        3'd3: alsu_out <= {3'b000, A} * {3'b000, B};
        3'd4: alsu_out <= direction ? {alsu_out[4:0], serial_in} : {serial_in, alsu_out[5:1]};
        3'd5: alsu_out <= direction ? {alsu_out[4:0], alsu_out[5]} : {alsu_out[0], alsu_out[5:1]};
        default: alsu_out <= '0;
      endcase
    end
  end

  function automatic logic [15:0] mk(input logic [2:0] a, input logic [2:0] b,
                                     input logic [2:0] op, input logic ci,
                                     input logic red_a, input logic byp_a);
    return {a, b, op, ci, 1'b0, 1'b0, red_a, 1'b0, byp_a, 1'b0};
  endfunction

  function automatic logic bad_cmd(input logic [15:0] c);
    logic [2:0] op;
    op = c[9:7];
    return (op >= 3'd6) || ((c[3] || c[2]) && (op > 3'd1));
  endfunction

  // Result of a legal, non-shift command as computed by the ALSU stand-in.
  function automatic logic [5:0] model(input logic [15:0] c);
    logic [2:0] a, b, op;
    a  = c[15:13];
    b  = c[12:10];
    op = c[9:7];
    if (c[1]) return {3'b000, a};
    if (c[0]) return {3'b000, b};
    case (op)
      3'd0: return c[3] ? {5'b0, &a} : c[2] ? {5'b0, &b} : {3'b000, a & b};
      3'd1: return c[3] ? {5'b0, ^a} : c[2] ? {5'b0, ^b} : {3'b000, a ^ b};
      3'd2: return 6'(a) + 6'(b) + 6'(c[6]);
      3'd3: return 6'(a) * 6'(b);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] c);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {15'b0, cmd_ready}, 16'd1);
    cmd_valid = 1'b1;
    cmd_data  = c;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    e.err  = bad_cmd(c);
    e.data = e.err ? 6'd0 : model(c);
    sb.push_back(e);
  endtask

  // Waits (bounded) for a response, checks it against the queue head, then
  // lets one edge pass so it is consumed when rsp_ready is high.
  task automatic get_rsp(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {15'b0, rsp_valid}, 16'd1);
    chk({tag, "_sb"}, {15'b0, (sb.size() > 0)}, 16'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, {10'b0, rsp_data}, {10'b0, e.data});
      chk({tag, "_err"}, {15'b0, rsp_err}, {15'b0, e.err});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c1;
    logic [15:0] bp[5];
    logic        seen;

    // Reset then idle
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {15'b0, cmd_ready}, 16'd1);
    chk("rst_valid", {15'b0, rsp_valid}, 16'd0);
    chk("rst_busy", {15'b0, busy}, 16'd0);
    chk("rst_pins", pins, 16'd0);
    chk("rst_errcnt", {8'b0, err_count}, 16'd0);
    chk("rst_data", {10'b0, rsp_data}, 16'd0);
    rst = 1'b0;

    // Legal add: 3 + 5 + cin = 9, latency check
    rsp_ready = 1'b1;
    c1 = mk(3'd3, 3'd5, 3'd2, 1'b1, 1'b0, 1'b0);
    push(c1);                                   // edge T
    @(negedge clk); chk("pins_T", pins, 16'd0);
    @(negedge clk); chk("pins_T1", pins, 16'd0);
    chk("busy_T1", {15'b0, busy}, 16'd1);
    @(negedge clk); chk("pins_T2", pins, c1);
    @(negedge clk); chk("valid_T3", {15'b0, rsp_valid}, 16'd0);
    @(negedge clk); chk("valid_T4", {15'b0, rsp_valid}, 16'd1);
    get_rsp("add");

    // Illegal opcode 7
    push(mk(3'd1, 3'd1, 3'd7, 1'b0, 1'b0, 1'b0));
    get_rsp("op7");
    chk("op7_pins", pins, c1);
    chk("op7_errcnt", {8'b0, err_count}, 16'd1);

    // Illegal reduction on opcode 3
    push(mk(3'd2, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0));
    get_rsp("red3");
    chk("red3_pins", pins, c1);
    chk("red3_errcnt", {8'b0, err_count}, 16'd2);

    // Backpressure: DEPTH+1 pushes while responses are held
    rsp_ready = 1'b0;
    bp[0] = mk(3'd2, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0);
    bp[1] = mk(3'd7, 3'd7, 3'd2, 1'b1, 1'b0, 1'b0);
    bp[2] = mk(3'd5, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0);
    bp[3] = mk(3'd6, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0);
    bp[4] = mk(3'd4, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) push(bp[i]);
    @(negedge clk);
    chk("bp_full", {15'b0, cmd_ready}, 16'd0);
    repeat (4) @(negedge clk);
    chk("bp_hold_valid", {15'b0, rsp_valid}, 16'd1);
    chk("bp_hold_data", {10'b0, rsp_data}, 16'd6);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) get_rsp("bp");
    @(negedge clk);
    chk("bp_idle", {15'b0, busy}, 16'd0);

    // Reset mid-operation: first command in WAIT, three queued
    for (int i = 0; i < 4; i++) push(mk(3'(i + 1), 3'd2, 3'd2, 1'b0, 1'b0, 1'b0));
    chk("mid_busy", {15'b0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("mid_valid", {15'b0, rsp_valid}, 16'd0);
    chk("mid_ready", {15'b0, cmd_ready}, 16'd1);
    chk("mid_busy0", {15'b0, busy}, 16'd0);
    chk("mid_pins", pins, 16'd0);
    chk("mid_errcnt", {8'b0, err_count}, 16'd0);
    sb.delete();
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_stale", {15'b0, seen}, 16'd0);

    // Saturation of err_count
    for (int i = 0; i < 260; i++) begin
      push(mk(3'(i), 3'd0, 3'd6, 1'b0, 1'b0, 1'b0));
      get_rsp("sat");
      if (i == 253) chk("sat_254", {8'b0, err_count}, 16'd254);
      if (i == 254) chk("sat_255", {8'b0, err_count}, 16'd255);
    end
    chk("sat_final", {8'b0, err_count}, 16'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
